// File: rtl/exc_pkg.sv
// Shared ExcCode values, FSM state encoding and default vectors for the
// exception sequencer.
`default_nettype none

package exc_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;

  localparam logic [31:0] DEF_VEC_ADDR = 32'h0000_0180;
  localparam logic [31:0] DEF_RST_VEC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAVE   = 2'd1,
    VECTOR = 2'd2,
    RET    = 2'd3
  } exc_state_t;

endpackage

`default_nettype wire

// File: rtl/exc_ctrl_if.sv
// Pipeline/CP0 signal bundle of the exception sequencer; the slave modport
// is the sequencer side, the master modport the pipeline/CP0 side.
`default_nettype none

interface exc_ctrl_if;
  logic [4:0]  Int;
  logic        Addr_Err;
  logic        EXC_RI;
  logic        EXC_Sys;
  logic        EXC_Bp;
  logic        EXC_Ov;
  logic        EXC_Tr;
  logic        ERET;
  logic [31:0] pc_cur;
  logic        sr_ie;
  logic        sr_exl;
  logic [4:0]  sr_im;
  logic [31:0] epc_in;
  logic        stall;
  logic        flush;
  logic        pc_sel;
  logic [31:0] pc_target;
  logic        epc_we;
  logic [31:0] epc_wdata;
  logic        cause_we;
  logic [4:0]  cause_exccode;
  logic [4:0]  cause_ip;
  logic        exl_set;
  logic        exl_clr;
  logic        busy;

  modport slave (
    input  Int, Addr_Err, EXC_RI, EXC_Sys, EXC_Bp, EXC_Ov, EXC_Tr, ERET,
           pc_cur, sr_ie, sr_exl, sr_im, epc_in,
    output stall, flush, pc_sel, pc_target, epc_we, epc_wdata, cause_we,
           cause_exccode, cause_ip, exl_set, exl_clr, busy
  );

  modport master (
    output Int, Addr_Err, EXC_RI, EXC_Sys, EXC_Bp, EXC_Ov, EXC_Tr, ERET,
           pc_cur, sr_ie, sr_exl, sr_im, epc_in,
    input  stall, flush, pc_sel, pc_target, epc_we, epc_wdata, cause_we,
           cause_exccode, cause_ip, exl_set, exl_clr, busy
  );
endinterface

`default_nettype wire

// File: rtl/exc_prio_enc.sv
// Fixed-priority exception encoder: picks the highest-priority pending
// cause and reports {valid, exccode}.
`default_nettype none

module exc_prio_enc
  import exc_pkg::*;
(
  input  wire logic       addr_err,
  input  wire logic       ri,
  input  wire logic       sys,
  input  wire logic       bp,
  input  wire logic       ov,
  input  wire logic       tr,
  input  wire logic       int_req,
  output logic            valid,
  output logic [4:0]      exccode
);

  always_comb begin
    valid   = 1'b1;
    exccode = EXC_INT;
    if (addr_err)     exccode = EXC_ADEL;
    else if (ri)      exccode = EXC_RI;
    else if (sys)     exccode = EXC_SYS;
    else if (bp)      exccode = EXC_BP;
    else if (ov)      exccode = EXC_OV;
    else if (tr)      exccode = EXC_TR;
    else if (int_req) exccode = EXC_INT;
    else              valid   = 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer driving CP0 EPC/Cause/EXL writes and the PC
// redirect. Optional macro EXC_INT_SYNC_EN adds a 2-flop Int synchroniser.
`default_nettype none

module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] VEC_ADDR = DEF_VEC_ADDR,
  parameter logic [31:0] RST_VEC  = DEF_RST_VEC
) (
  input  wire logic   clk,
  input  wire logic   rst,
  exc_ctrl_if.slave   bus
);

  exc_state_t  r_state;
  exc_state_t  w_next;
  logic [31:0] r_pc;
  logic [4:0]  r_code;
  logic [4:0]  w_int;
  logic        w_int_req;
  logic        w_valid;
  logic [4:0]  w_code;

`ifdef EXC_INT_SYNC_EN
  logic [4:0] r_int_s1;
  logic [4:0] r_int_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_int_s1 <= '0;
      r_int_s2 <= '0;
    end else begin
      r_int_s1 <= bus.Int;
      r_int_s2 <= r_int_s1;
    end
  end

  assign w_int = r_int_s2;
`else
  assign w_int = bus.Int;
`endif

  assign bus.cause_ip = w_int & bus.sr_im;
  assign w_int_req    = bus.sr_ie & ~bus.sr_exl & (|bus.cause_ip);

  exc_prio_enc u_prio (
    .addr_err (bus.Addr_Err),
    .ri       (bus.EXC_RI),
    .sys      (bus.EXC_Sys),
    .bp       (bus.EXC_Bp),
    .ov       (bus.EXC_Ov),
    .tr       (bus.EXC_Tr),
    .int_req  (w_int_req),
    .valid    (w_valid),
    .exccode  (w_code)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pc    <= RST_VEC;
      r_code  <= EXC_INT;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_valid) begin
        r_pc   <= bus.pc_cur;
        r_code <= w_code;
      end
    end
  end

  // Outputs are a pure decode of the state so an async reset clears them at once.
  always_comb begin
    w_next            = r_state;
    bus.stall         = 1'b0;
    bus.flush         = 1'b0;
    bus.pc_sel        = 1'b0;
    bus.pc_target     = RST_VEC;
    bus.epc_we        = 1'b0;
    bus.epc_wdata     = r_pc;
    bus.cause_we      = 1'b0;
    bus.cause_exccode = r_code;
    bus.exl_set       = 1'b0;
    bus.exl_clr       = 1'b0;
    bus.busy          = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_valid)       w_next = SAVE;
        else if (bus.ERET) w_next = RET;
      end
      SAVE: begin
        bus.stall    = 1'b1;
        bus.epc_we   = 1'b1;
        bus.cause_we = 1'b1;
        bus.exl_set  = 1'b1;
        bus.busy     = 1'b1;
        w_next       = VECTOR;
      end
      VECTOR: begin
        bus.stall     = 1'b1;
        bus.pc_sel    = 1'b1;
        bus.pc_target = VEC_ADDR;
        bus.flush     = 1'b1;
        bus.busy      = 1'b1;
        w_next        = IDLE;
      end
      RET: begin
        bus.stall     = 1'b1;
        bus.pc_sel    = 1'b1;
        bus.pc_target = bus.epc_in;
        bus.exl_clr   = 1'b1;
        bus.flush     = 1'b1;
        bus.busy      = 1'b1;
        w_next        = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: a schedule-based model of the expected
// output cycles plus directed literal checks.
`default_nettype none

module tb_exc_ctrl;
  import exc_pkg::*;

  localparam logic [31:0] VEC  = 32'h0000_0180;
  localparam logic [31:0] RSTV = 32'h0000_0000;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        pc_sel;
    logic [31:0] pc_target;
    logic        epc_we;
    logic [31:0] epc_wdata;
    logic        cause_we;
    logic [4:0]  code;
    logic        exl_set;
    logic        exl_clr;
    logic        busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];
  logic [4:0] d1 = '0;
  logic [4:0] d2 = '0;

  always #5 clk = ~clk;

  exc_ctrl_if bus();

  exc_ctrl #(.VEC_ADDR(VEC), .RST_VEC(RSTV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] eff_int();
`ifdef EXC_INT_SYNC_EN
    return d2;
`else
    return bus.Int;
`endif
  endfunction

  // Cycle schedule: when nothing is pending, the inputs at this edge decide
  // which output cycles follow; otherwise the cycle just ended is retired.
  task automatic model_edge();
    logic        flags [7];
    logic [4:0]  codes [7];
    logic        int_req;
    logic        found;
    logic [4:0]  code;
    exp_t        e;
    if (!rst) begin
      q.delete();
      d1 = '0;
      d2 = '0;
      return;
    end
    if (q.size() == 0) begin
      int_req = bus.sr_ie & ~bus.sr_exl & (|(eff_int() & bus.sr_im));
      flags = '{bus.Addr_Err, bus.EXC_RI, bus.EXC_Sys, bus.EXC_Bp, bus.EXC_Ov, bus.EXC_Tr, int_req};
      codes = '{5'd4, 5'd10, 5'd8, 5'd9, 5'd12, 5'd13, 5'd0};
      found = 1'b0;
      code  = '0;
      for (int i = 0; i < 7; i++) begin
        if (!found && flags[i]) begin
          found = 1'b1;
          code  = codes[i];
        end
      end
      if (found) begin
        e = '0;
        e.stall = 1'b1; e.busy = 1'b1; e.epc_we = 1'b1; e.epc_wdata = bus.pc_cur;
        e.cause_we = 1'b1; e.code = code; e.exl_set = 1'b1;
        q.push_back(e);
        e = '0;
        e.stall = 1'b1; e.busy = 1'b1; e.pc_sel = 1'b1; e.pc_target = VEC; e.flush = 1'b1;
        q.push_back(e);
      end else if (bus.ERET) begin
        e = '0;
        e.stall = 1'b1; e.busy = 1'b1; e.pc_sel = 1'b1; e.pc_target = bus.epc_in;
        e.flush = 1'b1; e.exl_clr = 1'b1;
        q.push_back(e);
      end
    end else begin
      void'(q.pop_front());
    end
    d2 = d1;
    d1 = bus.Int;
  endtask

  task automatic compare();
    exp_t e;
    e = '0;
    if (q.size() != 0) e = q[0];
    check("stall",    32'(bus.stall),    32'(e.stall));
    check("flush",    32'(bus.flush),    32'(e.flush));
    check("pc_sel",   32'(bus.pc_sel),   32'(e.pc_sel));
    check("epc_we",   32'(bus.epc_we),   32'(e.epc_we));
    check("cause_we", 32'(bus.cause_we), 32'(e.cause_we));
    check("exl_set",  32'(bus.exl_set),  32'(e.exl_set));
    check("exl_clr",  32'(bus.exl_clr),  32'(e.exl_clr));
    check("busy",     32'(bus.busy),     32'(e.busy));
    check("cause_ip", 32'(bus.cause_ip), 32'(eff_int() & bus.sr_im));
    if (e.epc_we)   check("epc_wdata", bus.epc_wdata, e.epc_wdata);
    if (e.cause_we) check("exccode", 32'(bus.cause_exccode), 32'(e.code));
    if (e.pc_sel)   check("pc_target", bus.pc_target, e.pc_target);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic clear_flags();
    bus.Addr_Err = 1'b0; bus.EXC_RI = 1'b0; bus.EXC_Sys = 1'b0;
    bus.EXC_Bp = 1'b0; bus.EXC_Ov = 1'b0; bus.EXC_Tr = 1'b0; bus.ERET = 1'b0;
  endtask

  initial begin
    int n;
    int lat;
    rst = 1'b0;
    clear_flags();
    bus.Int = '0; bus.pc_cur = '0; bus.sr_ie = 1'b0; bus.sr_exl = 1'b0;
    bus.sr_im = '0; bus.epc_in = '0;
    repeat (2) tick();
    check("rst_busy",      32'(bus.busy),          32'd0);
    check("rst_stall",     32'(bus.stall),         32'd0);
    check("rst_pc_target", bus.pc_target,          32'h0);
    check("rst_epc_wdata", bus.epc_wdata,          32'h0);
    check("rst_exccode",   32'(bus.cause_exccode), 32'd0);
    rst = 1'b1;
    repeat (2) tick();

    // Overflow entry
    bus.EXC_Ov = 1'b1; bus.pc_cur = 32'h0000_0040;
    tick();
    clear_flags();
    check("ov_epc_we",    32'(bus.epc_we),        32'd1);
    check("ov_epc_wdata", bus.epc_wdata,          32'h40);
    check("ov_exccode",   32'(bus.cause_exccode), 32'd12);
    check("ov_exl_set",   32'(bus.exl_set),       32'd1);
    check("ov_stall1",    32'(bus.stall),         32'd1);
    tick();
    check("ov_pc_sel",    32'(bus.pc_sel),        32'd1);
    check("ov_pc_target", bus.pc_target,          32'h180);
    check("ov_flush",     32'(bus.flush),         32'd1);
    check("ov_stall2",    32'(bus.stall),         32'd1);
    tick();
    check("ov_done_busy", 32'(bus.busy),          32'd0);

    // Three simultaneous exceptions: address error wins, one sequence
    bus.Addr_Err = 1'b1; bus.EXC_RI = 1'b1; bus.EXC_Sys = 1'b1; bus.pc_cur = 32'h0000_0100;
    tick();
    clear_flags();
    check("multi_exccode", 32'(bus.cause_exccode), 32'd4);
    n = int'(bus.epc_we);
    repeat (4) begin tick(); n += int'(bus.epc_we); end
    check("multi_once", 32'(n), 32'd1);

    // Enabled interrupt and its entry latency
    bus.sr_ie = 1'b1; bus.sr_exl = 1'b0; bus.sr_im = 5'b00100;
    bus.pc_cur = 32'h0000_0200; bus.Int = 5'b00100;
    lat = 0;
    for (int i = 0; i < 8 && !bus.epc_we; i++) begin tick(); lat++; end
`ifdef EXC_INT_SYNC_EN
    check("int_latency", 32'(lat), 32'd3);
`else
    check("int_latency", 32'(lat), 32'd1);
`endif
    check("int_exccode", 32'(bus.cause_exccode), 32'd0);
    check("int_cause_ip", 32'(bus.cause_ip), 32'h4);
    bus.Int = '0;
    repeat (4) tick();

    // Interrupt masked by EXL, then by IM
    bus.sr_exl = 1'b1; bus.Int = 5'b00100;
    n = 0;
    repeat (6) begin tick(); n += int'(bus.busy); end
    check("int_exl_busy", 32'(n), 32'd0);
    bus.sr_exl = 1'b0; bus.sr_im = '0;
    n = 0;
    repeat (6) begin tick(); n += int'(bus.busy); end
    check("int_im_busy", 32'(n), 32'd0);
    check("int_im_cause_ip", 32'(bus.cause_ip), 32'd0);
    bus.Int = '0;
    repeat (3) tick();

    // ERET
    bus.ERET = 1'b1; bus.epc_in = 32'h0000_1234;
    tick();
    clear_flags();
    check("eret_pc_sel",    32'(bus.pc_sel),  32'd1);
    check("eret_pc_target", bus.pc_target,    32'h1234);
    check("eret_exl_clr",   32'(bus.exl_clr), 32'd1);
    check("eret_flush",     32'(bus.flush),   32'd1);
    tick();
    check("eret_done_busy", 32'(bus.busy),    32'd0);

    // ERET together with break: break wins, EXL is never cleared
    bus.ERET = 1'b1; bus.EXC_Bp = 1'b1; bus.pc_cur = 32'h0000_0300;
    tick();
    clear_flags();
    check("bp_exccode", 32'(bus.cause_exccode), 32'd9);
    n = int'(bus.exl_clr);
    repeat (4) begin tick(); n += int'(bus.exl_clr); end
    check("bp_no_exl_clr", 32'(n), 32'd0);

    // Async reset during SAVE
    bus.EXC_Tr = 1'b1; bus.pc_cur = 32'h0000_0400;
    tick();
    clear_flags();
    check("tr_epc_we", 32'(bus.epc_we), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_stall",     32'(bus.stall),    32'd0);
    check("arst_epc_we",    32'(bus.epc_we),   32'd0);
    check("arst_cause_we",  32'(bus.cause_we), 32'd0);
    check("arst_exl_set",   32'(bus.exl_set),  32'd0);
    check("arst_busy",      32'(bus.busy),     32'd0);
    check("arst_pc_target", bus.pc_target,     32'h0);
    check("arst_epc_wdata", bus.epc_wdata,     32'h0);
    tick();
    rst = 1'b1;
    repeat (2) tick();
    check("post_rst_busy", 32'(bus.busy), 32'd0);

    // A few back-to-back vectors judged by the model alone
    bus.sr_im = 5'b11111;
    bus.EXC_Sys = 1'b1; bus.pc_cur = 32'h0000_0500;
    tick(); clear_flags();
    bus.EXC_Ov = 1'b1; bus.EXC_Tr = 1'b1; bus.pc_cur = 32'h0000_0504;
    repeat (2) tick();
    clear_flags();
    repeat (3) tick();
    bus.Int = 5'b00001; bus.ERET = 1'b1; bus.pc_cur = 32'h0000_0600;
    tick(); clear_flags(); bus.Int = '0;
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
Exception/interrupt sequencer that drives the CP0 register file.
- Each cycle it samples the pipeline's exception flags, the five hardware interrupts and ERET.
- It picks one winner by fixed priority and walks a short FSM that writes EPC, Cause.ExcCode and Status.EXL in CP0.
- It then redirects the PC to the exception vector, or back to EPC on ERET, stalling and flushing the pipeline while it does so.
- It sits between the ID/EX exception-detect logic and CP0, and owns all CP0 writes except mtc0.

Parameters:
VEC_ADDR, 32'h0000_0180, exception/interrupt vector target
RST_VEC, 32'h0000_0000, value of pc_target and epc_wdata after reset

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
Int  in  5  hardware interrupt lines, level-sensitive
Addr_Err  in  1  address error (fetch or data)
EXC_RI  in  1  reserved instruction
EXC_Sys  in  1  syscall
EXC_Bp  in  1  break
EXC_Ov  in  1  integer overflow
EXC_Tr  in  1  trap
ERET  in  1  ERET in decode
pc_cur  in  32  PC of the instruction carrying the flags
sr_ie  in  1  Status.IE from CP0
sr_exl  in  1  Status.EXL from CP0
sr_im  in  5  Status.IM[14:10] from CP0
epc_in  in  32  current CP0 EPC
stall  out  1  freeze IF/ID/EX
flush  out  1  squash IF/ID/EX contents, one-cycle pulse
pc_sel  out  1  PC mux override, one-cycle pulse
pc_target  out  32  override PC
epc_we  out  1  CP0 EPC write strobe
epc_wdata  out  32  EPC value
cause_we  out  1  CP0 Cause write strobe
cause_exccode  out  5  Cause[6:2]
cause_ip  out  5  Cause[14:10], live pending interrupts
exl_set  out  1  set Status.EXL
exl_clr  out  1  clear Status.EXL
busy  out  1  FSM not in IDLE

Behaviour:
Reset values: all strobes (stall, flush, pc_sel, epc_we, cause_we, exl_set, exl_clr, busy) are 0; cause_exccode=0; pc_target and epc_wdata are RST_VEC; state is IDLE.

- cause_ip = Int & sr_im (combinational; Int passes through the synchroniser when EXC_INT_SYNC_EN is defined).
- int_req = sr_ie & ~sr_exl & |cause_ip.
- Priority, highest first, with ExcCode:
  - Addr_Err = 4
  - RI = 10
  - Sys = 8
  - Bp = 9
  - Ov = 12
  - Tr = 13
  - int_req = 0
- Synchronous exceptions are taken even when EXL=1 (no nesting protection; EPC is overwritten).

FSM, one state per cycle:
- IDLE: when any exception or int_req is present, latch exccode and pc_cur into internal registers and go to SAVE. Otherwise, if ERET is present, go to RET. Otherwise stay. No outputs are asserted in IDLE.
- SAVE: stall=1; epc_we=1, epc_wdata=latched pc; cause_we=1, cause_exccode=latched code; exl_set=1. Go to VECTOR.
- VECTOR: stall=1, pc_sel=1, pc_target=VEC_ADDR, flush=1. Go to IDLE.
- RET: stall=1, pc_sel=1, pc_target=epc_in, exl_clr=1, flush=1. Go to IDLE.

Timing and edge cases:
- Entry latency: PC redirect occurs 2 cycles after detection. ERET latency is 1 cycle.
- busy=1 in SAVE, VECTOR and RET.
- Exception and ERET in the same cycle: the exception wins and ERET is dropped (it is flushed).
- Inputs seen while not in IDLE are ignored (the pipeline is stalled, so the flags persist or are flushed).
- An interrupt that is deasserted before reaching IDLE is not taken.
- Reset mid-sequence: go to IDLE immediately and deassert all strobes. Any partial CP0 write is abandoned.
- Only one strobe cycle per event; strobes never overlap across states.

Optional Feature:
EXC_INT_SYNC_EN: when defined, Int passes through a 2-flop synchroniser (reset 0), adding 2 cycles of interrupt latency. When undefined, Int is used directly, on the assumption that the interrupt sources are synchronous to clk.

Decomposition:
- Shared package exc_pkg:
  - ExcCode constants EXC_INT=0, EXC_ADEL=4, EXC_SYS=8, EXC_BP=9, EXC_RI=10, EXC_OV=12, EXC_TR=13.
  - FSM state encoding: IDLE, SAVE, VECTOR, RET.
  - Default VEC_ADDR.
- One sub-module: exc_prio_enc, a combinational priority encoder producing {valid, exccode[4:0]} from the flags and int_req.

Test Plan:
- EXC_Ov=1, pc_cur=32'h0000_0040 in IDLE -> next cycle epc_we=1, epc_wdata=32'h40, cause_exccode=12, exl_set=1; following cycle pc_sel=1, pc_target=32'h180, flush=1; stall=1 for both cycles.
- Addr_Err, EXC_RI and EXC_Sys together -> cause_exccode=4; only one entry sequence occurs.
- Int=5'b00100, sr_im=5'b00100, sr_ie=1, sr_exl=0 -> cause_ip=5'b00100 and an entry sequence with code 0. Repeat with sr_exl=1 or sr_im=0 -> no sequence; busy stays 0.
- ERET with epc_in=32'h0000_1234 -> next cycle pc_sel=1, pc_target=32'h1234, exl_clr=1, flush=1. ERET together with EXC_Bp -> code 9 entry; exl_clr is never asserted.
- Assert rst low during SAVE -> all outputs reset values asynchronously. After release the FSM sits in IDLE with busy=0.
- With EXC_INT_SYNC_EN defined, an enabled interrupt causes epc_we 3 cycles after Int rises, versus 1 cycle without the macro.
